// File: rtl/pair_fifo_pkg.sv
// Shared types and helpers for the byte-pair FIFO: word packing and the
// 9-bit pair sum presented alongside each stored word.
package pair_fifo_pkg;

  localparam int BYTE_W = 8;
  localparam int WORD_W = 16;
  localparam int SUM_W  = 9;

  typedef logic [WORD_W-1:0] pair_word_t;

  function automatic pair_word_t pack_pair(input logic [BYTE_W-1:0] a,
                                           input logic [BYTE_W-1:0] b);
    return {a, b};
  endfunction

  // Both bytes are widened first so the carry out of the add is kept.
  function automatic logic [SUM_W-1:0] pair_sum(input pair_word_t word);
    return {1'b0, word[WORD_W-1:BYTE_W]} + {1'b0, word[BYTE_W-1:0]};
  endfunction

endpackage

// File: rtl/pair_fifo_mem.sv
// DEPTH x WORD_W register array: synchronous write port, combinational read port.
module pair_fifo_mem
  import pair_fifo_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  pair_word_t      wdata,
  input  logic [AW-1:0]   raddr,
  output pair_word_t      rdata
);

  pair_word_t mem [DEPTH];

  // NOTE: storage is deliberately left out of reset; validity is tracked by
  // the pointers, and a reset on the array would only cost flops and routing.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/pair_word_fifo.sv
// Byte-pair buffering stage: packs (a, b) into {a, b}, stores up to DEPTH
// words in order and tracks current and peak occupancy.
module pair_word_fifo
  import pair_fifo_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [BYTE_W-1:0]  in_a,
  input  logic [BYTE_W-1:0]  in_b,
  output logic               in_ready,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WORD_W-1:0]  out_data,
  output logic [SUM_W-1:0]   out_sum,
  output logic [PTR_W-1:0]   level,
  output logic [PTR_W-1:0]   peak,
  input  logic               peak_clr
);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
    $error("pair_word_fifo: DEPTH must be a power of 2 and at least 2");
  end

  localparam logic [PTR_W-1:0] FULL_LEVEL = PTR_W'(DEPTH);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] peak_q;
  logic [PTR_W-1:0] next_level;
  logic             push;
  logic             pop;
  pair_word_t       rd_word;

  // The extra wrap bit lets the plain difference distinguish full from empty.
  assign level     = wr_ptr - rd_ptr;
  assign in_ready  = (level != FULL_LEVEL);
  assign out_valid = (level != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // NOTE: combinational blocks use blocking assignments and give every output
  // a default first, so no path leaves a value held (which would infer a latch).
  always_comb begin
    next_level = level;
    if (push && !pop)      next_level = level + 1'b1;
    else if (pop && !push) next_level = level - 1'b1;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      peak_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      // A clear records the post-update level, so a clear during a push counts it.
      if (peak_clr)                 peak_q <= next_level;
      else if (next_level > peak_q) peak_q <= next_level;
    end
  end

  assign peak = peak_q;

  pair_fifo_mem #(.DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr[PTR_W-2:0]),
    .wdata (pack_pair(in_a, in_b)),
    .raddr (rd_ptr[PTR_W-2:0]),
    .rdata (rd_word)
  );

  assign out_data = rd_word;
  assign out_sum  = pair_sum(rd_word);

endmodule

// File: tb/tb_pair_word_fifo.sv
// Directed self-checking bench for pair_word_fifo with DEPTH = 4.
module tb_pair_word_fifo;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [8:0]  out_sum;
  logic [2:0]  level;
  logic [2:0]  peak;
  logic        peak_clr;

  int tests_run = 0;
  int failures  = 0;

  always #5 clk = ~clk;

  pair_word_fifo #(.DEPTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sum   (out_sum),
    .level     (level),
    .peak      (peak),
    .peak_clr  (peak_clr)
  );

  // Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
  task automatic cycle(input logic v, input logic [7:0] a, input logic [7:0] b,
                       input logic r, input logic clr);
    @(negedge clk);
    in_valid = v; in_a = a; in_b = b; out_ready = r; peak_clr = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0; peak_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if ({out_valid, in_ready, level, peak} !== {1'b0, 1'b1, 3'd0, 3'd0}) begin
      failures++;
      $display("FAIL reset_state: got valid=%b ready=%b level=%0d peak=%0d, want 0 1 0 0",
               out_valid, in_ready, level, peak);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single_push;
    cycle(1'b1, 8'h12, 8'h34, 1'b0, 1'b0);
    tests_run++;
    if ({out_valid, out_data, out_sum, level, peak} !== {1'b1, 16'h1234, 9'h046, 3'd1, 3'd1}) begin
      failures++;
      $display("FAIL single_push: got valid=%b data=%h sum=%h level=%0d peak=%0d, want 1 1234 046 1 1",
               out_valid, out_data, out_sum, level, peak);
    end
    cycle(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
    tests_run++;
    if ({out_valid, level, peak} !== {1'b0, 3'd0, 3'd1}) begin
      failures++;
      $display("FAIL single_pop: got valid=%b level=%0d peak=%0d, want 0 0 1", out_valid, level, peak);
    end
  endtask

  task automatic test_full;
    logic [15:0] exp_word;
    for (int i = 1; i <= 4; i++) begin
      cycle(1'b1, 8'(i * 16), 8'(i), 1'b0, 1'b0);
      tests_run++;
      if (level !== 3'(i)) begin
        failures++;
        $display("FAIL fill_level_%0d: got %0d want %0d", i, level, i);
      end
    end
    tests_run++;
    if ({in_ready, out_data, peak} !== {1'b0, 16'h1001, 3'd4}) begin
      failures++;
      $display("FAIL full_flags: got ready=%b data=%h peak=%0d, want 0 1001 4", in_ready, out_data, peak);
    end
    // A fifth pair offered while full must be held, not taken.
    cycle(1'b1, 8'h55, 8'h66, 1'b0, 1'b0);
    tests_run++;
    if ({in_ready, level, out_data} !== {1'b0, 3'd4, 16'h1001}) begin
      failures++;
      $display("FAIL full_hold: got ready=%b level=%0d data=%h, want 0 4 1001", in_ready, level, out_data);
    end
    cycle(1'b1, 8'h55, 8'h66, 1'b1, 1'b0);
    tests_run++;
    if ({in_ready, level, out_data} !== {1'b1, 3'd3, 16'h2002}) begin
      failures++;
      $display("FAIL full_pop: got ready=%b level=%0d data=%h, want 1 3 2002", in_ready, level, out_data);
    end
    for (int i = 2; i <= 4; i++) begin
      exp_word = {8'(i * 16), 8'(i)};
      tests_run++;
      if (out_data !== exp_word) begin
        failures++;
        $display("FAIL drain_order_%0d: got %h want %h", i, out_data, exp_word);
      end
      cycle(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
    end
    tests_run++;
    if ({out_valid, level} !== {1'b0, 3'd0}) begin
      failures++;
      $display("FAIL full_drained: got valid=%b level=%0d, want 0 0", out_valid, level);
    end
  endtask

  task automatic test_carry;
    cycle(1'b1, 8'hFF, 8'hFF, 1'b0, 1'b0);
    tests_run++;
    if ({out_data, out_sum} !== {16'hFFFF, 9'h1FE}) begin
      failures++;
      $display("FAIL sum_carry: got data=%h sum=%h, want ffff 1fe", out_data, out_sum);
    end
    cycle(1'b1, 8'h80, 8'h7F, 1'b1, 1'b0);
    tests_run++;
    if ({out_data, out_sum} !== {16'h807F, 9'h0FF}) begin
      failures++;
      $display("FAIL sum_no_carry: got data=%h sum=%h, want 807f 0ff", out_data, out_sum);
    end
    cycle(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back;
    logic [15:0] exp_word;
    cycle(1'b1, 8'h80, 8'h00, 1'b0, 1'b0);
    cycle(1'b1, 8'h81, 8'h01, 1'b0, 1'b0);
    for (int i = 2; i < 12; i++) begin
      exp_word = {8'(8'h80 + i - 2), 8'(i - 2)};
      tests_run++;
      if (out_data !== exp_word) begin
        failures++;
        $display("FAIL b2b_data_%0d: got %h want %h", i, out_data, exp_word);
      end
      cycle(1'b1, 8'(8'h80 + i), 8'(i), 1'b1, 1'b0);
      tests_run++;
      if (level !== 3'd2) begin
        failures++;
        $display("FAIL b2b_level_%0d: got %0d want 2", i, level);
      end
    end
    for (int i = 10; i < 12; i++) begin
      exp_word = {8'(8'h80 + i), 8'(i)};
      tests_run++;
      if (out_data !== exp_word) begin
        failures++;
        $display("FAIL b2b_tail_%0d: got %h want %h", i, out_data, exp_word);
      end
      cycle(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
    end
  endtask

  task automatic test_peak;
    cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    tests_run++;
    if ({level, peak} !== {3'd0, 3'd0}) begin
      failures++;
      $display("FAIL peak_clear_idle: got level=%0d peak=%0d, want 0 0", level, peak);
    end
    repeat (3) cycle(1'b1, 8'h01, 8'h02, 1'b0, 1'b0);
    repeat (3) cycle(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
    tests_run++;
    if ({level, peak} !== {3'd0, 3'd3}) begin
      failures++;
      $display("FAIL peak_hold: got level=%0d peak=%0d, want 0 3", level, peak);
    end
    cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    tests_run++;
    if (peak !== 3'd0) begin
      failures++;
      $display("FAIL peak_clear: got %0d want 0", peak);
    end
    cycle(1'b1, 8'h09, 8'h08, 1'b0, 1'b1);
    tests_run++;
    if ({level, peak} !== {3'd1, 3'd1}) begin
      failures++;
      $display("FAIL peak_clear_push: got level=%0d peak=%0d, want 1 1", level, peak);
    end
    cycle(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic test_reset_mid;
    repeat (3) cycle(1'b1, 8'h33, 8'h44, 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b1; in_a = 8'h77; in_b = 8'h88;
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({out_valid, in_ready, level, peak} !== {1'b0, 1'b1, 3'd0, 3'd0}) begin
      failures++;
      $display("FAIL reset_async: got valid=%b ready=%b level=%0d peak=%0d, want 0 1 0 0",
               out_valid, in_ready, level, peak);
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b1;
    cycle(1'b1, 8'hAB, 8'hCD, 1'b0, 1'b0);
    tests_run++;
    if ({out_valid, out_data, out_sum, level, peak} !== {1'b1, 16'hABCD, 9'h178, 3'd1, 3'd1}) begin
      failures++;
      $display("FAIL reset_recover: got valid=%b data=%h sum=%h level=%0d peak=%0d, want 1 abcd 178 1 1",
               out_valid, out_data, out_sum, level, peak);
    end
  endtask

  initial begin
    test_reset;
    test_single_push;
    test_full;
    test_carry;
    test_back_to_back;
    test_peak;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
